// File: rtl/div_sched_pkg.sv
// Shared state encodings, geometry defaults and width helper for the divider scratch scheduler.
package div_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_RD_ISSUE  = 3'd1;
  localparam state_t S_RD_WAIT   = 3'd2;
  localparam state_t S_DIV_START = 3'd3;
  localparam state_t S_DIV_WAIT  = 3'd4;
  localparam state_t S_WR_ISSUE  = 3'd5;
  localparam state_t S_WR_GAP    = 3'd6;
  localparam state_t S_DONE      = 3'd7;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_NUM_DIV     = 8;
  localparam int DEF_NUM_LINES   = 64;
  localparam int DEF_LPB         = 2;
  localparam int DEF_RD_BASE     = 64;
  localparam int DEF_WT_BASE     = 128;
  localparam int DEF_RD_LAT      = 2;
  localparam int DEF_WT_GAP      = 2;
  localparam int DEF_TIMEOUT_CYC = 1024;

  // ceil(log2(n)), never below 1 so single-entry fields keep a legal width
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/div_rd_valid_pipe.sv
// Delays {read strobe, line slot} by RD_LAT cycles to mark returning scratch data; latency RD_LAT.
// No backpressure: shifts every cycle, reset flushes all in-flight entries.
module div_rd_valid_pipe #(
  parameter int RD_LAT = 2,
  parameter int IDX_W  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_en,
  input  logic [IDX_W-1:0] issue_idx,
  output logic             data_rdy,
  output logic [IDX_W-1:0] data_idx
);

  logic [RD_LAT-1:0] vld_sr;
  logic [IDX_W-1:0]  idx_sr [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_sr[i] <= '0;
    end else begin
      vld_sr[0] <= issue_en;
      idx_sr[0] <= issue_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end
    end
  end

  assign data_rdy = vld_sr[RD_LAT-1];
  assign data_idx = idx_sr[RD_LAT-1];

endmodule

// File: rtl/div_sched_mem_ctrl.sv
// Batch scheduler: read LPB lines, run dividers, write LPB lines, repeat; first rd_en 1 cycle after start.
// No backpressure on memory; waits on div_done. Optional watchdog under DIV_TIMEOUT_EN.
module div_sched_mem_ctrl
  import div_sched_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int NUM_DIV         = DEF_NUM_DIV,
  parameter int NUM_LINES       = DEF_NUM_LINES,
  parameter int LINES_PER_BATCH = DEF_LPB,
  parameter int RD_BASE         = DEF_RD_BASE,
  parameter int WT_BASE         = DEF_WT_BASE,
  parameter int RD_LAT          = DEF_RD_LAT,
  parameter int WT_GAP          = DEF_WT_GAP,
  parameter int TIMEOUT_CYC     = DEF_TIMEOUT_CYC
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [NUM_DIV-1:0]                         div_done,
  output logic                                       rd_en,
  output logic [ADDR_W-1:0]                          rd_addr,
  output logic                                       rd_data_rdy,
  output logic [clog2_min1(LINES_PER_BATCH)-1:0]     rd_idx,
  output logic                                       div_start,
  output logic                                       wt_en,
  output logic [ADDR_W-1:0]                          wt_addr,
  output logic [clog2_min1(LINES_PER_BATCH)-1:0]     wt_idx,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       err
);

  localparam int IDX_W     = clog2_min1(LINES_PER_BATCH);
  localparam int CNT_W     = IDX_W + 1;
  localparam int NUM_BATCH = NUM_LINES / LINES_PER_BATCH;
  localparam int BAT_W     = clog2_min1(NUM_BATCH) + 1;

  localparam logic [CNT_W-1:0]  LPB_C      = CNT_W'(LINES_PER_BATCH);
  localparam logic [CNT_W-1:0]  LAST_SLOT  = CNT_W'(LINES_PER_BATCH - 1);
  localparam logic [BAT_W-1:0]  LAST_BATCH = BAT_W'(NUM_BATCH - 1);
  localparam logic [3:0]        GAP_LAST   = 4'((WT_GAP == 0) ? 0 : WT_GAP - 1);
  localparam logic [ADDR_W-1:0] RD_BASE_A  = ADDR_W'(RD_BASE);
  localparam logic [ADDR_W-1:0] WT_BASE_A  = ADDR_W'(WT_BASE);

  state_t             state, nxt, after_wr;
  logic [CNT_W-1:0]   rd_cnt, wt_cnt;
  logic [BAT_W-1:0]   batch_cnt;
  logic [3:0]         gap_cnt;
  logic [NUM_DIV-1:0] done_seen;
  logic               all_done, last_wr, timeout;

  // Lanes finishing in the current cycle count immediately
  assign all_done = &(done_seen | div_done);
  assign wt_idx   = wt_cnt[IDX_W-1:0];

`ifdef DIV_TIMEOUT_EN
  localparam int TO_W = clog2_min1(TIMEOUT_CYC) + 1;
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign timeout = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == S_DIV_WAIT) ? to_cnt + TO_W'(1) : '0;
      if (state == S_IDLE && start)
        err_q <= 1'b0;
      else if (state == S_DIV_WAIT && !all_done && timeout)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    // wt_cnt is bumped as each write leaves WR_ISSUE, so the gap sees the post-write count
    last_wr  = (state == S_WR_ISSUE) ? (wt_cnt == LAST_SLOT) : (wt_cnt == LPB_C);
    after_wr = S_WR_ISSUE;
    if (last_wr) after_wr = (batch_cnt == LAST_BATCH) ? S_DONE : S_RD_ISSUE;
    nxt = state;
    case (state)
      S_IDLE:      if (start) nxt = S_RD_ISSUE;
      S_RD_ISSUE:  if (rd_cnt == LAST_SLOT) nxt = S_RD_WAIT;
      S_RD_WAIT:   if (rd_data_rdy && ({1'b0, rd_idx} == LAST_SLOT)) nxt = S_DIV_START;
      S_DIV_START: nxt = S_DIV_WAIT;
      S_DIV_WAIT:  if (all_done) nxt = S_WR_ISSUE;
                   else if (timeout) nxt = S_DONE;
      S_WR_ISSUE:  nxt = (WT_GAP != 0) ? S_WR_GAP : after_wr;
      S_WR_GAP:    if (gap_cnt == GAP_LAST) nxt = after_wr;
      S_DONE:      nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rd_en     <= 1'b0;
      div_start <= 1'b0;
      wt_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_addr   <= RD_BASE_A;
      wt_addr   <= WT_BASE_A;
      rd_cnt    <= '0;
      wt_cnt    <= '0;
      batch_cnt <= '0;
      gap_cnt   <= '0;
      done_seen <= '0;
    end else begin
      state     <= nxt;
      rd_en     <= (nxt == S_RD_ISSUE);
      div_start <= (nxt == S_DIV_START);
      wt_en     <= (nxt == S_WR_ISSUE);
      done      <= (nxt == S_DONE);
      busy      <= (nxt != S_IDLE);
      case (state)
        S_IDLE: if (start) begin
          rd_addr   <= RD_BASE_A;
          wt_addr   <= WT_BASE_A;
          rd_cnt    <= '0;
          wt_cnt    <= '0;
          batch_cnt <= '0;
        end
        S_RD_ISSUE: begin
          rd_addr <= rd_addr + ADDR_W'(1);
          rd_cnt  <= rd_cnt + CNT_W'(1);
        end
        S_DIV_START: begin
          done_seen <= '0;
          rd_cnt    <= '0;
          wt_cnt    <= '0;
        end
        S_DIV_WAIT: done_seen <= done_seen | div_done;
        S_WR_ISSUE: begin
          wt_addr <= wt_addr + ADDR_W'(1);
          wt_cnt  <= wt_cnt + CNT_W'(1);
          gap_cnt <= '0;
        end
        S_WR_GAP: gap_cnt <= gap_cnt + 4'd1;
        default: ;
      endcase
      if ((state == S_WR_ISSUE || state == S_WR_GAP) && nxt == S_RD_ISSUE)
        batch_cnt <= batch_cnt + BAT_W'(1);
    end
  end

  div_rd_valid_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (IDX_W)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .issue_en  (rd_en),
    .issue_idx (rd_cnt[IDX_W-1:0]),
    .data_rdy  (rd_data_rdy),
    .data_idx  (rd_idx)
  );

endmodule
